// File: rtl/stream_buffer_flushable.sv
// Flushable elastic stream buffer: Depth-entry circular FIFO whose ready depends on state only.
// Define STREAM_BUFFER_FALLTHROUGH_EN to add a zero-latency bypass while the buffer is empty.
module stream_buffer_flushable #(
    parameter int unsigned DataWidth = 32,
    parameter int unsigned Depth     = 4,
    parameter int unsigned CntWidth  = $clog2(Depth + 1)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 flush_i,
    input  logic                 valid_i,
    output logic                 ready_o,
    input  logic [DataWidth-1:0] data_i,
    output logic                 valid_o,
    input  logic                 ready_i,
    output logic [DataWidth-1:0] data_o,
    output logic [CntWidth-1:0]  usage_o,
    output logic                 full_o,
    output logic                 empty_o
);
    localparam int unsigned PtrWidth = (Depth > 1) ? $clog2(Depth) : 1;
    localparam logic [PtrWidth-1:0] LastPtr = PtrWidth'(Depth - 1);
    localparam logic [CntWidth-1:0] FullCnt = CntWidth'(Depth);

    if (Depth < 2 || DataWidth < 1) begin : gen_param_err
        $error("stream_buffer_flushable: Depth must be >= 2 and DataWidth >= 1");
    end

    logic [DataWidth-1:0] mem_q [Depth];
    logic [PtrWidth-1:0]  wr_q;
    logic [PtrWidth-1:0]  rd_q;
    logic [CntWidth-1:0]  cnt_q;
    logic                 is_empty;
    logic                 push;
    logic                 pop;

    function automatic logic [PtrWidth-1:0] next_ptr(input logic [PtrWidth-1:0] p);
        return (p == LastPtr) ? '0 : p + 1'b1;
    endfunction

    assign is_empty = (cnt_q == '0);
    assign ready_o  = (cnt_q != FullCnt);
    assign usage_o  = cnt_q;
    assign full_o   = ~ready_o;
    assign empty_o  = is_empty;

`ifdef STREAM_BUFFER_FALLTHROUGH_EN
    logic bypass;
    // Empty with downstream ready: the beat goes straight through and is never stored.
    assign bypass  = is_empty & ready_i;
    assign valid_o = is_empty ? (valid_i & ~flush_i) : 1'b1;
    assign data_o  = is_empty ? data_i : mem_q[rd_q];
    assign push    = valid_i & ready_o & ~flush_i & ~bypass;
    assign pop     = ~is_empty & ready_i & ~flush_i;
`else
    assign valid_o = ~is_empty;
    assign data_o  = mem_q[rd_q];
    assign push    = valid_i & ready_o & ~flush_i;
    assign pop     = valid_o & ready_i & ~flush_i;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
            for (int i = 0; i < Depth; i++) begin
                mem_q[i] <= '0;
            end
        end else if (flush_i) begin
            // Storage is left as is; only the bookkeeping is cleared.
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push) begin
                mem_q[wr_q] <= data_i;
                wr_q        <= next_ptr(wr_q);
            end
            if (pop) begin
                rd_q <= next_ptr(rd_q);
            end
            if (push && !pop) begin
                cnt_q <= cnt_q + 1'b1;
            end else if (pop && !push) begin
                cnt_q <= cnt_q - 1'b1;
            end
        end
    end

endmodule
